// File: rtl/gt_pattern_loader.sv
// Programs the gt_data_path pattern RAM from a stream of NUM_CH*CH_W-bit words,
// one channel slice per cycle, pulsing gt_reset first and enabling playback last.
//
// state | meaning
// IDLE  | no session; waiting for load_req
// RST   | gt_reset held high for RST_CYC cycles
// WAIT  | s_ready high until a word is accepted
// WR    | NUM_CH slice writes of the captured word
// FIN   | done pulse, gt_start rises
module gt_pattern_loader #(
  parameter int NUM_CH  = 6,
  parameter int CH_W    = 32,
  parameter int ADDR_W  = 8,
  parameter int RST_CYC = 4
) (
  input  logic                     axilite_clk,
  input  logic                     axilite_rstb,
  input  logic                     load_req,
  input  logic [ADDR_W-1:0]        load_len,
  input  logic                     abort,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*CH_W-1:0]   s_data,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [CH_W-1:0]          ram_data,
  output logic                     ram_we,
  output logic [3:0]               ram_idx,
  output logic                     gt_reset,
  output logic                     gt_start,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              rst_cnt_q;
  logic [3:0]              ch_q;
  logic [ADDR_W-1:0]       wcnt_q;
  logic [ADDR_W-1:0]       len_q;
  logic [NUM_CH*CH_W-1:0]  word_q;
  logic                    start_q;
  logic                    err_q;

  logic load_acc, last_ch, last_word, rst_tc;

  assign load_acc  = (state_q == S_IDLE) && load_req && !abort;
  assign last_ch   = (ch_q == 4'(NUM_CH - 1));
  assign last_word = (wcnt_q == len_q);
  assign rst_tc    = (rst_cnt_q == 4'd0);

  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (load_acc) state_d = S_RST;
        S_RST:   if (rst_tc) state_d = S_WAIT;
        S_WAIT:  if (s_valid) state_d = S_WR;
        S_WR:    if (last_ch) state_d = last_word ? S_FIN : S_WAIT;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Exit test on wcnt precedes the increment, so len_q = 2**ADDR_W-1 never wraps.
  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      rst_cnt_q <= '0;
      ch_q      <= '0;
      wcnt_q    <= '0;
      len_q     <= '0;
      word_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_acc) begin
            len_q     <= load_len;
            wcnt_q    <= '0;
            ch_q      <= '0;
            rst_cnt_q <= 4'(RST_CYC - 1);
          end
        end
        S_RST: begin
          if (!rst_tc) rst_cnt_q <= rst_cnt_q - 4'd1;
        end
        S_WAIT: begin
          if (s_valid) begin
            word_q <= s_data;
            ch_q   <= '0;
          end
        end
        S_WR: begin
          if (last_ch) begin
            ch_q <= '0;
            if (!last_word) wcnt_q <= wcnt_q + 1'b1;
          end else begin
            ch_q <= ch_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (load_acc) begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (abort) begin
      start_q <= 1'b0;
      if (state_q != S_IDLE) err_q <= 1'b1;
    end else if (state_q == S_WR && last_ch && last_word) begin
      start_q <= 1'b1;
    end
  end

  always_comb begin
    s_ready  = 1'b0;
    ram_we   = 1'b0;
    gt_reset = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    gt_start = start_q;
    err      = err_q;
    ram_addr = wcnt_q;
    ram_idx  = ch_q;
    ram_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 4'(c)) ram_data = word_q[c*CH_W +: CH_W];
    end
    case (state_q)
      S_RST:   gt_reset = 1'b1;
      S_WAIT:  s_ready  = 1'b1;
      S_WR:    ram_we   = 1'b1;
      S_FIN:   done     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gt_pattern_loader.sv
// Bench for gt_pattern_loader: a timestamp-based session model predicts every
// output each cycle; directed scenarios add literal count/latency expectations.
module tb_gt_pattern_loader;
  localparam int NUM_CH  = 6;
  localparam int CH_W    = 32;
  localparam int ADDR_W  = 8;
  localparam int RST_CYC = 4;
  localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2, P_WR = 3, P_FIN = 4;

  logic                    axilite_clk = 1'b0;
  logic                    axilite_rstb = 1'b0;
  logic                    load_req = 1'b0;
  logic [ADDR_W-1:0]       load_len = '0;
  logic                    abort = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [NUM_CH*CH_W-1:0]  s_data = '0;
  logic [ADDR_W-1:0]       ram_addr;
  logic [CH_W-1:0]         ram_data;
  logic                    ram_we;
  logic [3:0]              ram_idx;
  logic                    gt_reset, gt_start, busy, done, err;

  gt_pattern_loader #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .RST_CYC(RST_CYC)) dut (
    .axilite_clk(axilite_clk), .axilite_rstb(axilite_rstb),
    .load_req(load_req), .load_len(load_len), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_idx(ram_idx),
    .gt_reset(gt_reset), .gt_start(gt_start), .busy(busy), .done(done), .err(err)
  );

  always #5 axilite_clk = ~axilite_clk;

  int n_checks = 0, n_errors = 0, cyc = 0;

  // Session model: cycle c follows posedge c; a session starts at edge t_start,
  // spends RST_CYC cycles in reset, and each word accepted at edge t_acc is
  // written during cycles t_acc..t_acc+NUM_CH-1.
  bit                      m_act = 0, m_start = 0, m_err = 0;
  int                      t_start = 0, t_acc = 0, acc_cnt = 0, n_words = 0;
  logic [NUM_CH*CH_W-1:0]  m_word = '0;

  int valid_mode = 0;
  int we_cnt = 0, done_cnt = 0, rise_cnt = 0, done_cyc = 0, last_addr = 0, last_idx = 0, req_cyc = 0;
  logic prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int phase_of(input int c, output int slice);
    int d;
    slice = 0;
    if (!m_act) return P_IDLE;
    if (c - t_start < RST_CYC) return P_RST;
    if (acc_cnt == 0) return P_WAIT;
    d = c - t_acc;
    if (d < NUM_CH) begin
      slice = d;
      return P_WR;
    end
    if (acc_cnt == n_words) return P_FIN;
    return P_WAIT;
  endfunction

  initial begin : model
    int p, sl, e;
    forever begin
      @(posedge axilite_clk);
      e = cyc + 1;
      if (!axilite_rstb) begin
        m_act = 0; m_start = 0; m_err = 0; acc_cnt = 0;
      end else begin
        p = phase_of(cyc, sl);
        if (m_act && abort) begin
          m_act = 0; m_err = 1; m_start = 0;
        end else if (m_act) begin
          if (p == P_WAIT && s_valid) begin
            acc_cnt++; t_acc = e; m_word = s_data;
          end else if (p == P_WR && sl == NUM_CH - 1 && acc_cnt == n_words) begin
            m_start = 1;
          end else if (p == P_FIN) begin
            m_act = 0;
          end
        end else if (abort) begin
          m_start = 0;
        end else if (load_req) begin
          m_act = 1; t_start = e; acc_cnt = 0; n_words = int'(load_len) + 1;
          m_err = 0; m_start = 0;
        end
      end
      cyc = e;
    end
  end

  initial begin : compare
    int p, sl;
    forever begin
      @(negedge axilite_clk);
      if (axilite_rstb) begin
        p = phase_of(cyc, sl);
        chk("busy",     32'(busy),     32'(p != P_IDLE));
        chk("gt_reset", 32'(gt_reset), 32'(p == P_RST));
        chk("s_ready",  32'(s_ready),  32'(p == P_WAIT));
        chk("ram_we",   32'(ram_we),   32'(p == P_WR));
        chk("done",     32'(done),     32'(p == P_FIN));
        chk("gt_start", 32'(gt_start), 32'(m_start));
        chk("err",      32'(err),      32'(m_err));
        if (p == P_WR) begin
          chk("ram_addr", 32'(ram_addr), 32'(acc_cnt - 1));
          chk("ram_idx",  32'(ram_idx),  32'(sl));
          chk("ram_data", ram_data,      m_word[sl*CH_W +: CH_W]);
        end
        if (ram_we) begin we_cnt++; last_addr = int'(ram_addr); last_idx = int'(ram_idx); end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (gt_start && !prev_start) rise_cnt++;
        prev_start = gt_start;
      end else begin
        prev_start = 1'b0;
      end
    end
  end

  initial begin : stream
    forever begin
      @(negedge axilite_clk);
      for (int c = 0; c < NUM_CH; c++) s_data[c*CH_W +: CH_W] = $urandom;
      s_valid = (valid_mode == 1) ? 1'b1 : (valid_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic clear_counts();
    we_cnt = 0; done_cnt = 0; rise_cnt = 0; done_cyc = 0; last_addr = 0; last_idx = 0;
  endtask

  task automatic pulse_load(input int len);
    load_req = 1'b1;
    load_len = ADDR_W'(len);
    req_cyc  = cyc;
    @(negedge axilite_clk);
    load_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (m_act && i < budget) begin
      @(negedge axilite_clk);
      i++;
    end
    chk("session_end", 32'(m_act), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flags"}, 32'({s_ready, ram_we, gt_reset, gt_start, busy, done, err}), 32'd0);
    chk({tag, "_addr"},  32'(ram_addr), 32'd0);
    chk({tag, "_idx"},   32'(ram_idx),  32'd0);
    chk({tag, "_data"},  ram_data,      32'd0);
  endtask

  initial begin : main
    int p, sl, k;
    repeat (3) @(negedge axilite_clk);
    check_all_zero("reset");
    axilite_rstb = 1'b1;
    repeat (5) @(negedge axilite_clk);
    chk("idle_s_ready", 32'(s_ready), 32'd0);

    // three words, stream always valid
    clear_counts(); valid_mode = 1;
    pulse_load(2);
    wait_idle(200);
    chk("three_writes", 32'(we_cnt), 32'd18);
    chk("three_done", 32'(done_cnt), 32'd1);
    chk("three_latency", 32'(done_cyc - req_cyc), 32'd26);
    chk("three_last_addr", 32'(last_addr), 32'd2);
    chk("three_gt_start", 32'(gt_start), 32'd1);

    // backpressure
    clear_counts(); valid_mode = 2;
    pulse_load(9);
    wait_idle(2000);
    chk("bp_writes", 32'(we_cnt), 32'd60);
    chk("bp_start_rise", 32'(rise_cnt), 32'd1);
    chk("bp_done", 32'(done_cnt), 32'd1);

    // single word
    clear_counts(); valid_mode = 1;
    pulse_load(0);
    wait_idle(100);
    chk("one_writes", 32'(we_cnt), 32'd6);

    // full depth
    clear_counts(); valid_mode = 1;
    pulse_load(255);
    wait_idle(3000);
    chk("full_writes", 32'(we_cnt), 32'd1536);
    chk("full_last_addr", 32'(last_addr), 32'd255);
    chk("full_last_idx", 32'(last_idx), 32'd5);
    chk("full_done", 32'(done_cnt), 32'd1);

    // abort at word 2, idx 3
    clear_counts(); valid_mode = 1;
    pulse_load(4);
    k = 0;
    p = phase_of(cyc, sl);
    while (!(p == P_WR && acc_cnt == 3 && sl == 3) && k < 200) begin
      @(negedge axilite_clk);
      p = phase_of(cyc, sl);
      k++;
    end
    abort = 1'b1;
    @(negedge axilite_clk);
    abort = 1'b0;
    chk("abort_we", 32'(ram_we), 32'd0);
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_start", 32'(gt_start), 32'd0);
    chk("abort_writes", 32'(we_cnt), 32'd16);
    clear_counts();
    pulse_load(1);
    chk("reload_err", 32'(err), 32'd0);
    wait_idle(200);
    chk("reload_writes", 32'(we_cnt), 32'd12);
    chk("reload_done", 32'(done_cnt), 32'd1);

    // load_req while busy is ignored
    clear_counts();
    pulse_load(1);
    repeat (3) @(negedge axilite_clk);
    pulse_load(7);
    wait_idle(300);
    chk("busy_req_writes", 32'(we_cnt), 32'd12);

    // load_req with abort in IDLE: no session, playback cleared
    load_req = 1'b1; abort = 1'b1; load_len = 8'd3;
    @(negedge axilite_clk);
    load_req = 1'b0; abort = 1'b0;
    repeat (2) @(negedge axilite_clk);
    chk("collide_busy", 32'(busy), 32'd0);
    chk("collide_start", 32'(gt_start), 32'd0);
    chk("collide_err", 32'(err), 32'd0);

    // asynchronous reset during WR
    valid_mode = 1;
    pulse_load(3);
    k = 0;
    p = phase_of(cyc, sl);
    while (p != P_WR && k < 100) begin
      @(negedge axilite_clk);
      p = phase_of(cyc, sl);
      k++;
    end
    #2 axilite_rstb = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge axilite_clk);
    @(negedge axilite_clk);
    axilite_rstb = 1'b1;
    repeat (2) @(negedge axilite_clk);

    // randomized sessions with stray requests and occasional aborts
    for (int it = 0; it < 10; it++) begin
      valid_mode = int'($urandom_range(1, 2));
      pulse_load(int'($urandom_range(0, 12)));
      k = int'($urandom_range(0, 80));
      for (int j = 0; j < k; j++) begin
        load_req = ($urandom_range(0, 15) == 0);
        load_len = 8'($urandom_range(0, 12));
        @(negedge axilite_clk);
      end
      load_req = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        abort = 1'b1;
        @(negedge axilite_clk);
        abort = 1'b0;
      end
      wait_idle(3000);
      repeat (2) @(negedge axilite_clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gt_pattern_loader.md
# gt_pattern_loader

Sequencer that programs the `gt_data_path` pattern RAM from a 192-bit word stream, then starts playback. Each word is split into six 32-bit channel writes on the `ram_addr`/`ram_data`/`ram_we`/`ram_idx` port, with no software register-pair pokes per channel. It runs in the AXI-Lite register domain beside `reg_map`. The block:

- pulses `gt_reset` before loading;
- asserts `gt_start` after the last write;
- reports `done` or `err` to software.

## Interface
Parameters:
- `NUM_CH`, 6, channel slices per word.
- `CH_W`, 32, bits per channel slice.
- `ADDR_W`, 8, RAM address width; supports up to 256 words.
- `RST_CYC`, 4, length of the `gt_reset` pulse in cycles, 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `axilite_clk`  in  1  sole clock, 100 MHz.
- `axilite_rstb`  in  1  asynchronous active-low reset.
- `load_req`  in  1  single-cycle request to start a load session; sampled only in IDLE.
- `load_len`  in  ADDR_W  number of words minus 1; sampled with `load_req`.
- `abort`  in  1  single-cycle session cancel.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  stream word accept.
- `s_data`  in  NUM_CH*CH_W  stream word; channel c is `s_data[c*CH_W +: CH_W]`.
- `ram_addr`  out  ADDR_W  word address to `gt_data_path`.
- `ram_data`  out  CH_W  channel slice data.
- `ram_we`  out  1  write strobe, one slice per cycle.
- `ram_idx`  out  4  channel index, 0..NUM_CH-1.
- `gt_reset`  out  1  datapath reset (maps to `reg_reset`).
- `gt_start`  out  1  playback enable level (maps to `reg_start`).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the load completes.
- `err`  out  1  sticky abort flag; cleared by the next accepted `load_req`.

## Operation
States:
- IDLE
- RST: `gt_reset`=1 for RST_CYC cycles.
- WAIT: `s_ready`=1 until a word is accepted.
- WR: NUM_CH cycles, `ram_we`=1.
- FIN: one cycle.

Transitions:
- IDLE -> RST when `load_req`=1 and `abort`=0.
  - Latch `load_len` into `len_q`.
  - Clear the word counter `wcnt` and `err`.
  - Drive `gt_start`=0 from the next cycle.
- RST -> WAIT after exactly RST_CYC cycles with `gt_reset`=1.
- WAIT -> WR on `s_valid && s_ready`; the 192-bit word is captured into `word_q`.
- WR, channel counter `ch` = 0..NUM_CH-1, one slice per cycle:
  - `ram_idx`=`ch`, `ram_addr`=`wcnt`, `ram_data`=`word_q[ch*CH_W +: CH_W]`, `ram_we`=1.
- WR exit on the `ch`=NUM_CH-1 cycle:
  - if `wcnt`==`len_q` -> FIN;
  - otherwise `wcnt`++ and -> WAIT.
- FIN -> IDLE.
  - `gt_start` is set to 1 and held until the next accepted `load_req`, `abort`, or reset.
  - `done`=1 for this one cycle.
- `abort` in any state other than IDLE -> IDLE on the next edge.
  - `ram_we`, `s_ready`, `gt_reset` and `gt_start` go 0.
  - `err`=1.
  - Words already written stay in the RAM.
- `abort` in IDLE: clears `gt_start` and does not set `err`.

Boundary rules:
- `load_req` while `busy`: ignored; `len_q` is unchanged.
- `load_req` and `abort` in the same cycle: `abort` wins.
- `load_len`=0 loads one word.
- `load_len`=255 loads addresses 0..255. `wcnt` never wraps because the exit test precedes the increment.
- `s_valid` is ignored outside WAIT; `s_ready` is 0 outside WAIT.
- Asynchronous reset mid-session: immediate return to IDLE with all outputs 0.

## Timing
- Reset values: every output is 0. State is IDLE, and all counters are 0.
- All outputs are registered; there is no combinational input-to-output path.
- `load_req` sampled at edge T:
  - `busy`=1 and `gt_reset`=1 during cycles T+1..T+RST_CYC;
  - `s_ready`=1 from cycle T+RST_CYC+1.
- Word accepted at edge E: `ram_we`=1 during cycles E+1..E+NUM_CH, with `ram_idx` 0..5 in order.
- Throughput: one word per NUM_CH+1 = 7 cycles when `s_valid` is held high.
- Last slice written in cycle L: `gt_start`=1 and `done`=1 in cycle L+1; `busy`=0 from cycle L+2.
- Total session latency for N words with no stalls: RST_CYC + 7N + 1 cycles from `load_req` to `done`.
- `ram_addr` and `ram_data` are stable throughout each `ram_we` cycle and are don't-care when `ram_we`=0.

## Test plan
- Reset check:
  - stimulus: hold `axilite_rstb`=0, then release;
  - response: all outputs 0; `s_ready` stays 0 until a `load_req` arrives.
- Three-word load:
  - stimulus: `load_len`=2, `s_valid` held high with random words, RST_CYC=4;
  - response: exactly 18 writes in (addr,idx) order (0,0)..(0,5),(1,0)..(2,5) with correct slices; `done` and `gt_start` rise 26 cycles after `load_req`.
- Backpressure:
  - stimulus: `load_len`=9, `s_valid` toggled randomly;
  - response: the same 60 writes; `ram_we`=0 whenever the block is in WAIT; `gt_start` asserts once.
- Full depth:
  - stimulus: `load_len`=255;
  - response: 1536 writes; the last write is addr 255, idx 5; no address wrap; `done` fires once.
- Abort mid-write:
  - stimulus: `abort` asserted at word 2, idx 3;
  - response: `ram_we`=0 next cycle; `err`=1; `gt_start`=0; `busy`=0.
  - follow-up: a new `load_req` clears `err` and the load completes normally.
- Collisions:
  - `load_req` while busy is ignored; the active session completes with its original length.
  - `load_req` together with `abort` in IDLE produces no session.
  - Asynchronous reset during WR zeroes all outputs immediately.
